// File: rtl/iiitb_imem_loader_if.sv
// Byte-stream ingress and IMEM write port of the program loader.
// master: stream source / IMEM sink side; slave: the loader itself.
// Write port is a one-cycle strobe with registered address and data.
interface iiitb_imem_loader_if #(
  parameter int AW = 6
);
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/iiitb_imem_loader.sv
// Framed byte-serial loader: assembles MSB-first words and writes them to IMEM 0..N-1.
// Latency: IMEM write one cycle after the 4th byte of a word; done one cycle after checksum.
// Backpressure: byte_ready is high in every state except DONE; no stall inside a frame.
module iiitb_imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                RN,
  iiitb_imem_loader_if.slave  bus,
  output logic                core_hold,
  output logic                done,
  output logic                err,
  output logic [AW:0]         words_loaded
);

  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   n_q;        // word count of the frame in progress
  logic [AW:0]   wcnt_q;     // words written so far in this frame
  logic [1:0]    bidx_q;     // byte position inside the current word
  logic [7:0]    acc_q;      // running XOR of data bytes
  logic [23:0]   word_q;     // first three bytes of the word being assembled
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          rdy;
  logic          accept;
  logic          is_hdr;
  logic          count_ok;
  logic          last_word;
  logic [AW:0]   wcnt_inc;

  assign accept    = bus.byte_valid && rdy;
  assign is_hdr    = (bus.byte_data == HDR);
  assign count_ok  = (bus.byte_data != 8'd0) && ({1'b0, bus.byte_data} <= DEPTH_W);
  assign wcnt_inc  = wcnt_q + (AW+1)'(1);
  assign last_word = (wcnt_inc == n_q);

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (RN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode driven by accepted bytes only.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && is_hdr) state_d = S_COUNT;
      S_COUNT: if (accept) state_d = count_ok ? S_DATA : S_ERR;
      S_DATA:  if (accept && (bidx_q == 2'd3) && last_word) state_d = S_CHECK;
      S_CHECK: if (accept) state_d = (bus.byte_data == acc_q) ? S_DONE : S_ERR;
      S_DONE:  state_d = S_DONE;
      S_ERR:   if (accept && is_hdr) state_d = S_COUNT;
      default: state_d = S_IDLE;
    endcase
  end

  // Status and flow-control outputs decoded from the current state.
  always_comb begin
    rdy       = 1'b1;
    core_hold = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_DONE: begin
        rdy       = 1'b0;
        core_hold = 1'b0;
        done      = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Word assembly, checksum accumulation and the registered IMEM write port.
  always_ff @(posedge clk) begin
    if (RN) begin
      n_q     <= '0;
      wcnt_q  <= '0;
      bidx_q  <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_COUNT: begin
            // An illegal count leaves the previous frame's counters untouched.
            if (count_ok) begin
              n_q    <= (AW+1)'(bus.byte_data);
              wcnt_q <= '0;
              bidx_q <= '0;
              acc_q  <= '0;
            end
          end
          S_DATA: begin
            word_q <= {word_q[15:0], bus.byte_data};
            acc_q  <= acc_q ^ bus.byte_data;
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= wcnt_q[AW-1:0];
              wdata_q <= {word_q, bus.byte_data};
              wcnt_q  <= wcnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready = rdy;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign words_loaded   = wcnt_q;

endmodule

// File: tb/tb_iiitb_imem_loader.sv
// Bench for iiitb_imem_loader: directed frames plus randomized frames, gaps and checksum faults.
// Expected writes/status are derived from the frame contents and pushed into queues.
// A negedge monitor pops and compares whenever the DUT strobes a write or raises done/err.
module tb_iiitb_imem_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   wl;
    int            cyc;
  } wr_t;

  typedef struct {
    logic done;
    logic err;
    int   cyc;
  } st_t;

  logic        clk = 1'b0;
  logic        RN  = 1'b1;
  logic        core_hold, done, err;
  logic [AW:0] words_loaded;

  iiitb_imem_loader_if #(.AW(AW)) ifc ();

  iiitb_imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .RN           (RN),
    .bus          (ifc.slave),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  wr_t         exp_wr[$];
  st_t         exp_st[$];
  logic [31:0] frame_w[$];
  logic        done_prev = 1'b0;
  logic        err_prev  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every write strobe and every done/err rising edge against the queues.
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    cyc++;
    if (ifc.imem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", 32'(ifc.imem_addr), 32'hFFFF_FFFF);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 32'(ifc.imem_addr), 32'(w.addr));
        chk("wr_data", ifc.imem_wdata, w.data);
        chk("wr_words_loaded", 32'(words_loaded), 32'(w.wl));
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
    if ((done === 1'b1 && !done_prev) || (err === 1'b1 && !err_prev)) begin
      if (exp_st.size() == 0) begin
        chk("unexpected_status", {30'd0, done, err}, 32'd0);
      end else begin
        s = exp_st.pop_front();
        chk("st_done", 32'(done), 32'(s.done));
        chk("st_err", 32'(err), 32'(s.err));
        chk("st_core_hold", 32'(core_hold), 32'(!s.done));
        chk("st_cycle", 32'(cyc), 32'(s.cyc));
      end
    end
    done_prev = (done === 1'b1);
    err_prev  = (err === 1'b1);
  end

  task automatic idle();
    @(negedge clk);
    ifc.byte_valid = 1'b0;
  endtask

  // Returns right after the rising edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      @(negedge clk);
      ifc.byte_valid = 1'b0;
    end
    @(negedge clk);
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = b;
    guard = 0;
    while (ifc.byte_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (ifc.byte_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_ready_timeout actual=%b required=1", ifc.byte_ready);
    end
    @(posedge clk);
  endtask

  // Sends header, count, frame_w words MSB-first and checksum (optionally corrupted).
  task automatic send_frame(input int gap, input logic [7:0] ck_flip);
    logic [7:0] ck;
    logic [7:0] by;
    wr_t        w;
    st_t        s;
    ck = 8'h00;
    send_byte(8'hA5, gap);
    send_byte(8'(frame_w.size()), gap);
    for (int k = 0; k < frame_w.size(); k++) begin
      for (int b = 3; b >= 0; b--) begin
        by = frame_w[k][8*b +: 8];
        ck = ck ^ by;
        send_byte(by, gap);
      end
      w.addr = AW'(k);
      w.data = frame_w[k];
      w.wl   = (AW+1)'(k + 1);
      w.cyc  = cyc + 1;
      exp_wr.push_back(w);
    end
    send_byte(ck ^ ck_flip, gap);
    s.done = (ck_flip == 8'h00);
    s.err  = (ck_flip != 8'h00);
    s.cyc  = cyc + 1;
    exp_st.push_back(s);
    idle();
  endtask

  task automatic send_count_err(input logic [7:0] n);
    st_t s;
    send_byte(8'hA5, 0);
    send_byte(n, 0);
    s.done = 1'b0;
    s.err  = 1'b1;
    s.cyc  = cyc + 1;
    exp_st.push_back(s);
    idle();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_wr.size() != 0 || exp_st.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    chk("drain_writes", 32'(exp_wr.size()), 32'd0);
    chk("drain_status", 32'(exp_st.size()), 32'd0);
    exp_wr.delete();
    exp_st.delete();
  endtask

  task automatic do_reset(input logic check);
    @(negedge clk);
    ifc.byte_valid = 1'b0;
    RN = 1'b1;
    @(negedge clk);
    RN = 1'b0;
    if (check) begin
      chk("rst_byte_ready", 32'(ifc.byte_ready), 32'd1);
      chk("rst_imem_we", 32'(ifc.imem_we), 32'd0);
      chk("rst_imem_addr", 32'(ifc.imem_addr), 32'd0);
      chk("rst_imem_wdata", ifc.imem_wdata, 32'd0);
      chk("rst_core_hold", 32'(core_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    end
  endtask

  task automatic load_scenario1();
    frame_w.delete();
    frame_w.push_back(32'h0220_8300);
    frame_w.push_back(32'h0220_9380);
  endtask

  initial begin
    ifc.byte_valid = 1'b0;
    ifc.byte_data  = 8'h00;
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] part[8];
    logic [7:0] g;
    logic [7:0] flip;
    wr_t        w;
    int         n;

    do_reset(1'b1);

    // Valid 2-word frame, back-to-back.
    load_scenario1();
    send_frame(0, 8'h00);
    drain();
    chk("s1_words_loaded", 32'(words_loaded), 32'd2);
    chk("s1_byte_ready_done", 32'(ifc.byte_ready), 32'd0);

    // Bad checksum, then the correct frame from ERR.
    do_reset(1'b0);
    send_frame(0, 8'h01);
    drain();
    chk("s2_core_hold_err", 32'(core_hold), 32'd1);
    chk("s2_done_err", 32'(done), 32'd0);
    send_frame(0, 8'h00);
    drain();
    chk("s2_err_cleared", 32'(err), 32'd0);

    // Illegal counts.
    do_reset(1'b0);
    send_count_err(8'h00);
    drain();
    do_reset(1'b0);
    send_count_err(8'h41);
    drain();
    chk("s3_words_loaded", 32'(words_loaded), 32'd0);

    // Garbage followed by a gapped frame.
    do_reset(1'b0);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    send_frame(3, 8'h00);
    drain();
    chk("s4_words_loaded", 32'(words_loaded), 32'd2);

    // Reset in the middle of the second word.
    do_reset(1'b0);
    part = '{8'hA5, 8'h02, 8'h02, 8'h20, 8'h83, 8'h00, 8'h02, 8'h20};
    for (int i = 0; i < 8; i++) begin
      send_byte(part[i], 0);
      if (i == 5) begin
        w.addr = '0;
        w.data = 32'h0220_8300;
        w.wl   = 7'd1;
        w.cyc  = cyc + 1;
        exp_wr.push_back(w);
      end
    end
    do_reset(1'b1);
    repeat (10) @(negedge clk);
    drain();
    load_scenario1();
    send_frame(0, 8'h00);
    drain();

    // Full depth: word k = k.
    do_reset(1'b0);
    frame_w.delete();
    for (int k = 0; k < DEPTH; k++) frame_w.push_back(32'(k));
    send_frame(0, 8'h00);
    drain();
    chk("full_words_loaded", 32'(words_loaded), 32'd64);

    // Randomized frames with garbage, gaps and checksum faults.
    for (int it = 0; it < 12; it++) begin
      do_reset(1'b0);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 0);
      end
      frame_w.delete();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) frame_w.push_back($urandom);
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame($urandom_range(0, 2), flip);
      drain();
      if (flip != 8'h00) begin
        send_frame($urandom_range(0, 2), 8'h00);
        drain();
      end
      chk("rand_words_loaded", 32'(words_loaded), 32'(n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
